inst_queue_p: RTL and testbench
===============================

# inst_queue_p

Parametrised instruction queue between the fetch unit (IF) and the decoder (ID). It buffers fetched instructions with their PC and branch-prediction bit, and pops one entry per request into a registered output stage. It has a programmable almost-full backpressure threshold, an exact occupancy count, overflow protection and a flush on `clear` (misprediction or rollback).

## Interface
Parameters:
- `DEPTH`, 16, number of entries; power of two, ≥ 4
- `ADDR_W`, 4, log2(DEPTH)
- `INST_W`, 32, instruction width
- `PC_W`, 32, PC width
- `AF_SLACK`, 3, backpressure margin; `if_stall` asserts when free slots ≤ AF_SLACK; must be < DEPTH

Ports:
- `clk_in` in 1: single clock; all logic on posedge
- `rst_in` in 1: synchronous, active-high reset
- `rdy_in` in 1: global enable; 0 freezes all state, outputs hold
- `clear` in 1: synchronous flush
- `push_in` in 1: IF presents an entry this cycle
- `inst_in` in INST_W: instruction
- `pc_in` in PC_W: PC
- `pred_in` in 1: predicted-taken bit
- `if_stall` out 1: registered almost-full to IF
- `pop_in` in 1: ID requests one entry
- `valid_out` out 1: registered; output fields valid this cycle
- `inst_out` out INST_W, `pc_out` out PC_W, `pred_out` out 1: registered head entry
- `empty_out` out 1: registered, count == 0
- `count_out` out ADDR_W+1: registered occupancy, 0..DEPTH
- `overflow_err` out 1: sticky; a push was dropped

## Operation
- Storage is DEPTH entries of {inst, pc, pred}. `head` and `tail` are ADDR_W-bit pointers that wrap naturally at DEPTH. `count` is a separate ADDR_W+1-bit register.
- Priority per edge: `rst_in` > `clear` > (`rdy_in` == 0: hold everything) > normal.
- Pop acceptance uses the current registered count: `pop_acc = pop_in && count != 0`.
  - On acceptance: output regs ← entry[head], `valid_out` ← 1, head ← head+1.
  - Otherwise `valid_out` ← 0 and the data outputs hold their last values.
- Push acceptance: `push_acc = push_in && (count < DEPTH || pop_acc)`.
  - On acceptance: entry[tail] ← inputs, tail ← tail+1.
  - `push_in` when full and not popping is dropped and sets `overflow_err`.
- No bypass. A push into an empty queue is not poppable in the same cycle.
- count_next = count + push_acc − pop_acc.
  - `count_out` ← count_next.
  - `empty_out` ← (count_next == 0).
  - `if_stall` ← (DEPTH − count_next ≤ AF_SLACK).
- Reset: head = tail = count = 0, `valid_out` = 0, `empty_out` = 1, `if_stall` = 0, `overflow_err` = 0, `inst_out`/`pc_out`/`pred_out` = 0. Array contents are don't-care.
- `clear`: same as reset except `overflow_err` holds. Same-cycle push/pop are discarded.
- `rdy_in` = 0: `push_in`/`pop_in` are ignored and every register holds, including `valid_out`. IF must not assert `push_in` while `rdy_in` is low.

## Timing
- Push at edge k: reflected in `count_out`/`empty_out`/`if_stall` after edge k. Earliest pop is sampled at edge k+1, with `valid_out` = 1 after edge k+1. Push-to-output latency is 2 edges.
- Pop sampled at edge k: data and `valid_out` are present for the cycle after edge k only. Back-to-back pops give one entry per cycle.
- `if_stall` is registered and seen by IF one cycle late. AF_SLACK covers in-flight IF pushes (3 for the current IF); overflow is then impossible in correct operation.
- `clear` at edge k: `valid_out` = 0 and `empty_out` = 1 after edge k. A push at k+1 is accepted normally.
- Wrap-around: pointers wrap from DEPTH−1 to 0 with no bubble. Full (count == DEPTH) and empty are distinguished by `count`, not by the pointers.

## Test plan
- Reset: after `rst_in` high for 1 edge → `valid_out` = 0, `empty_out` = 1, `count_out` = 0, `if_stall` = 0.
- Fill (DEPTH = 16, AF_SLACK = 3): push 13 entries, pc = 0x0, 0x4, … → `if_stall` rises after the 13th push edge with `count_out` = 13. Then pop 13 → `pc_out` = 0x0..0x30 in order, 1 per cycle, `empty_out` = 1 at the end.
- Wrap: push/pop 40 entries in a steady stream → order preserved across 2 pointer wraps, `count_out` stays ≤ 2.
- Full with simultaneous push and pop: at count = 16, push + pop → push accepted, popped entry is the oldest, `count_out` stays 16, `overflow_err` = 0. Push alone at 16 → entry dropped, `overflow_err` = 1.
- Clear mid-stream: count = 7 and `clear` coincident with push and pop → after the edge `count_out` = 0, `valid_out` = 0. The next push/pop returns only the new entry.
- Stall: `rdy_in` = 0 for 5 cycles with `pop_in` = 1 → all outputs frozen. After `rdy_in` returns, pops resume from the same head.

Source files
------------

// File: rtl/inst_queue_p.sv
// ---------------------------------------------------------------------------
// inst_queue_p
//
// Instruction queue sitting between the fetch unit (IF) and the decoder (ID).
// Holds {inst, pc, pred} entries in a circular buffer. Each accepted pop moves
// the head entry into a registered output stage. The queue also provides a
// registered almost-full stall to IF, an exact occupancy count, a sticky
// overflow flag and a flush input.
//
// Ports:
//   clk_in        - single clock, all logic on the rising edge
//   rst_in        - synchronous active-high reset
//   rdy_in        - global enable; low freezes every register
//   clear         - synchronous flush (misprediction / rollback)
//   push_in       - IF presents {inst_in, pc_in, pred_in} this cycle
//   inst_in       - instruction
//   pc_in         - PC of the instruction
//   pred_in       - predicted-taken bit
//   if_stall      - registered almost-full backpressure to IF
//   pop_in        - ID requests one entry
//   valid_out     - registered; output fields carry a fresh entry this cycle
//   inst_out      - registered head instruction
//   pc_out        - registered head PC
//   pred_out      - registered head prediction bit
//   empty_out     - registered, occupancy is zero
//   count_out     - registered occupancy, 0..DEPTH
//   overflow_err  - sticky; a push was dropped because the queue was full
// ---------------------------------------------------------------------------
module inst_queue_p #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int INST_W   = 32,
    parameter int PC_W     = 32,
    parameter int AF_SLACK = 3
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear,
    input  logic              push_in,
    input  logic [INST_W-1:0] inst_in,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              pred_in,
    output logic              if_stall,
    input  logic              pop_in,
    output logic              valid_out,
    output logic [INST_W-1:0] inst_out,
    output logic [PC_W-1:0]   pc_out,
    output logic              pred_out,
    output logic              empty_out,
    output logic [ADDR_W:0]   count_out,
    output logic              overflow_err
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AF_CNT   = (ADDR_W+1)'(AF_SLACK);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [INST_W-1:0] r_memInst [DEPTH];
    logic [PC_W-1:0]   r_memPc   [DEPTH];
    logic              r_memPred [DEPTH];

    logic [ADDR_W-1:0] r_head;
    logic [ADDR_W-1:0] r_tail;
    logic [ADDR_W:0]   r_count;

    logic              w_popAcc;
    logic              w_pushAcc;
    logic [ADDR_W:0]   w_countNext;
    logic [ADDR_W:0]   w_freeNext;
    logic              w_stallNext;

    // Acceptance decisions use the registered count only. A push into a full
    // queue is still legal when a pop frees the head slot in the same edge,
    // and there is no bypass: an entry pushed into an empty queue cannot be
    // popped until the following edge.
    always_comb begin
        w_popAcc    = pop_in && (r_count != '0);
        w_pushAcc   = push_in && ((r_count < FULL_CNT) || w_popAcc);
        w_countNext = r_count
                    + {{ADDR_W{1'b0}}, w_pushAcc}
                    - {{ADDR_W{1'b0}}, w_popAcc};
        w_freeNext  = FULL_CNT - w_countNext;
        w_stallNext = (w_freeNext <= AF_CNT);
    end

    // Storage array write port. The array is not reset; its contents only
    // matter between the pointers, which reset and clear already empty.
    always_ff @(posedge clk_in) begin
        if (!rst_in && !clear && rdy_in && w_pushAcc) begin
            r_memInst[r_tail] <= inst_in;
            r_memPc[r_tail]   <= pc_in;
            r_memPred[r_tail] <= pred_in;
        end
    end

    // Pointers, occupancy, status flags and the output stage. Reset beats
    // clear, clear beats the enable, and with rdy_in low every register
    // holds (valid_out included). Clear behaves like reset except that the
    // sticky overflow flag survives it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            valid_out    <= 1'b0;
            empty_out    <= 1'b1;
            if_stall     <= 1'b0;
            overflow_err <= 1'b0;
            inst_out     <= '0;
            pc_out       <= '0;
            pred_out     <= 1'b0;
        end else if (clear) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            valid_out    <= 1'b0;
            empty_out    <= 1'b1;
            if_stall     <= 1'b0;
            inst_out     <= '0;
            pc_out       <= '0;
            pred_out     <= 1'b0;
        end else if (rdy_in) begin
            if (w_popAcc) begin
                inst_out <= r_memInst[r_head];
                pc_out   <= r_memPc[r_head];
                pred_out <= r_memPred[r_head];
                r_head   <= r_head + PTR_ONE;
            end
            valid_out <= w_popAcc;
            if (w_pushAcc) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (push_in && !w_pushAcc) begin
                overflow_err <= 1'b1;
            end
            r_count   <= w_countNext;
            empty_out <= (w_countNext == '0);
            if_stall  <= w_stallNext;
        end
    end

    assign count_out = r_count;

endmodule

// File: tb/tb_inst_queue_p.sv
// ---------------------------------------------------------------------------
// tb_inst_queue_p
//
// Self-checking bench for inst_queue_p (DEPTH=16, AF_SLACK=3). A short table
// of hand-computed vectors is applied first, followed by directed sequences
// (fill/almost-full, full with push+pop, overflow, wrap-around, flush, enable
// stall) and a randomized run. A queue-based reference model predicts every
// output.
// ---------------------------------------------------------------------------
module tb_inst_queue_p;

    localparam int DEPTH    = 16;
    localparam int ADDR_W   = 4;
    localparam int INST_W   = 32;
    localparam int PC_W     = 32;
    localparam int AF_SLACK = 3;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic              rdy_in = 1'b1;
    logic              clear = 1'b0;
    logic              push_in = 1'b0;
    logic [INST_W-1:0] inst_in = '0;
    logic [PC_W-1:0]   pc_in = '0;
    logic              pred_in = 1'b0;
    logic              if_stall;
    logic              pop_in = 1'b0;
    logic              valid_out;
    logic [INST_W-1:0] inst_out;
    logic [PC_W-1:0]   pc_out;
    logic              pred_out;
    logic              empty_out;
    logic [ADDR_W:0]   count_out;
    logic              overflow_err;

    inst_queue_p #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INST_W(INST_W),
        .PC_W(PC_W), .AF_SLACK(AF_SLACK)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .push_in(push_in), .inst_in(inst_in), .pc_in(pc_in), .pred_in(pred_in),
        .if_stall(if_stall), .pop_in(pop_in), .valid_out(valid_out),
        .inst_out(inst_out), .pc_out(pc_out), .pred_out(pred_out),
        .empty_out(empty_out), .count_out(count_out),
        .overflow_err(overflow_err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
        logic              pred;
    } entry_t;

    typedef struct {
        bit          rst;
        bit          clr;
        bit          rdy;
        bit          push;
        bit          pop;
        logic [31:0] pc;
        bit          expValid;
        logic [31:0] expPc;
        int          expCount;
        bit          expEmpty;
        bit          expStall;
    } vec_t;

    entry_t      modelQ[$];
    bit          mValid;
    logic [31:0] mInst;
    logic [31:0] mPc;
    bit          mPred;
    bit          mOvf;

    int checks = 0;
    int failures = 0;

    // Instruction and prediction bit are derived from the PC so the data
    // fields carry distinct, checkable content.
    function automatic logic [31:0] instOf(input logic [31:0] pc);
        return pc ^ 32'hA5C3_0F00;
    endfunction

    function automatic bit predOf(input logic [31:0] pc);
        logic [31:0] p;
        p = pc;
        return p[2] ^ p[5];
    endfunction

    // Queue semantics stated directly: reset/flush empty the list, a disabled
    // cycle changes nothing, otherwise the oldest entry leaves first and a new
    // entry is appended when room exists (or is being made by that pop).
    task automatic modelEdge(input bit rst, input bit clr, input bit rdy,
                             input bit push, input bit pop,
                             input logic [31:0] pc);
        bit     popped;
        entry_t e;
        if (rst || clr) begin
            modelQ.delete();
            mValid = 0; mInst = '0; mPc = '0; mPred = 0;
            if (rst) mOvf = 0;
        end else if (rdy) begin
            popped = pop && (modelQ.size() > 0);
            if (popped) begin
                e = modelQ.pop_front();
                mInst = e.inst; mPc = e.pc; mPred = e.pred;
            end
            mValid = popped;
            if (push && (modelQ.size() < DEPTH || popped)) begin
                e.inst = instOf(pc); e.pc = pc; e.pred = predOf(pc);
                modelQ.push_back(e);
            end else if (push) begin
                mOvf = 1;
            end
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit clr, input bit rdy,
                                 input bit push, input bit pop,
                                 input logic [31:0] pc);
        rst_in = rst; clear = clr; rdy_in = rdy;
        push_in = push; pop_in = pop;
        pc_in = pc; inst_in = instOf(pc); pred_in = predOf(pc);
        @(posedge clk_in);
        modelEdge(rst, clr, rdy, push, pop, pc);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [63:0] act,
                            input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        int sz;
        sz = modelQ.size();
        checkVal({tag, ".valid"}, 64'(valid_out), 64'(mValid));
        checkVal({tag, ".inst"},  64'(inst_out),  64'(mInst));
        checkVal({tag, ".pc"},    64'(pc_out),    64'(mPc));
        checkVal({tag, ".pred"},  64'(pred_out),  64'(mPred));
        checkVal({tag, ".count"}, 64'(count_out), 64'(sz));
        checkVal({tag, ".empty"}, 64'(empty_out), 64'(sz == 0));
        checkVal({tag, ".stall"}, 64'(if_stall),  64'((DEPTH - sz) <= AF_SLACK));
        checkVal({tag, ".ovf"},   64'(overflow_err), 64'(mOvf));
    endtask

    vec_t vecs[12];

    initial begin
        // rst clr rdy push pop pc | valid pc count empty stall
        vecs[0]  = '{1, 0, 1, 0, 0, 32'h0,   0, 32'h0,   0, 1, 0};
        vecs[1]  = '{0, 0, 1, 1, 0, 32'h100, 0, 32'h0,   1, 0, 0};
        vecs[2]  = '{0, 0, 1, 1, 1, 32'h104, 1, 32'h100, 1, 0, 0};
        vecs[3]  = '{0, 0, 1, 0, 1, 32'h0,   1, 32'h104, 0, 1, 0};
        vecs[4]  = '{0, 0, 1, 0, 1, 32'h0,   0, 32'h104, 0, 1, 0};
        vecs[5]  = '{0, 0, 1, 1, 0, 32'h108, 0, 32'h104, 1, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 1, 32'h0,   0, 32'h104, 1, 0, 0};
        vecs[7]  = '{0, 0, 1, 0, 1, 32'h0,   1, 32'h108, 0, 1, 0};
        vecs[8]  = '{0, 0, 0, 0, 1, 32'h0,   1, 32'h108, 0, 1, 0};
        vecs[9]  = '{0, 1, 1, 1, 0, 32'h10c, 0, 32'h0,   0, 1, 0};
        vecs[10] = '{0, 0, 1, 1, 0, 32'h110, 0, 32'h0,   1, 0, 0};
        vecs[11] = '{0, 0, 1, 0, 1, 32'h0,   1, 32'h110, 0, 1, 0};

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].clr, vecs[i].rdy,
                          vecs[i].push, vecs[i].pop, vecs[i].pc);
            checkVal($sformatf("vec%0d.valid", i), 64'(valid_out), 64'(vecs[i].expValid));
            checkVal($sformatf("vec%0d.pc", i),    64'(pc_out),    64'(vecs[i].expPc));
            checkVal($sformatf("vec%0d.count", i), 64'(count_out), 64'(vecs[i].expCount));
            checkVal($sformatf("vec%0d.empty", i), 64'(empty_out), 64'(vecs[i].expEmpty));
            checkVal($sformatf("vec%0d.stall", i), 64'(if_stall),  64'(vecs[i].expStall));
        end

        // Fill to the almost-full threshold: stall must rise on the 13th push.
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkOutput("rst");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(0, 0, 1, 1, 0, 32'(i * 4));
            checkOutput($sformatf("fill%0d", i));
        end
        checkVal("fill.stall13", 64'(if_stall), 64'(1));
        checkVal("fill.count13", 64'(count_out), 64'(13));
        for (int i = 13; i < 16; i++) begin
            applyStimulus(0, 0, 1, 1, 0, 32'(i * 4));
        end
        checkVal("full.count", 64'(count_out), 64'(16));

        // Full queue: push together with pop is accepted, push alone is dropped.
        applyStimulus(0, 0, 1, 1, 1, 32'h40);
        checkOutput("fullPushPop");
        checkVal("fullPushPop.pc", 64'(pc_out), 64'(0));
        checkVal("fullPushPop.count", 64'(count_out), 64'(16));
        checkVal("fullPushPop.ovf", 64'(overflow_err), 64'(0));
        applyStimulus(0, 0, 1, 1, 0, 32'h44);
        checkVal("overflow.ovf", 64'(overflow_err), 64'(1));
        checkVal("overflow.count", 64'(count_out), 64'(16));
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 1, 0, 1, 0);
            checkOutput($sformatf("drain%0d", i));
        end
        checkVal("drain.lastPc", 64'(pc_out), 64'(32'h40));
        checkVal("drain.empty", 64'(empty_out), 64'(1));

        // Clear keeps the sticky flag; only reset drops it.
        applyStimulus(0, 1, 1, 0, 0, 0);
        checkVal("clear.ovfHeld", 64'(overflow_err), 64'(1));
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkOutput("rst2");

        // Steady stream across several pointer wraps.
        applyStimulus(0, 0, 1, 1, 0, 32'h1000);
        for (int i = 1; i <= 40; i++) begin
            applyStimulus(0, 0, 1, 1, 1, 32'(32'h1000 + i * 4));
            checkOutput($sformatf("wrap%0d", i));
            checkVal($sformatf("wrap%0d.pc", i), 64'(pc_out), 64'(32'h1000 + (i - 1) * 4));
            checkVal($sformatf("wrap%0d.countLe2", i), 64'(count_out <= 2), 64'(1));
        end
        applyStimulus(0, 0, 1, 0, 1, 0);
        checkOutput("wrapTail");

        // Flush mid-stream with coincident push and pop.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 0, 1, 1, 0, 32'(32'h2000 + i * 4));
        end
        applyStimulus(0, 1, 1, 1, 1, 32'h2100);
        checkVal("flush.count", 64'(count_out), 64'(0));
        checkVal("flush.valid", 64'(valid_out), 64'(0));
        applyStimulus(0, 0, 1, 1, 0, 32'h3000);
        applyStimulus(0, 0, 1, 0, 1, 0);
        checkOutput("flushNew");
        checkVal("flushNew.pc", 64'(pc_out), 64'(32'h3000));
        checkVal("flushNew.empty", 64'(empty_out), 64'(1));

        // Enable low for five cycles with pop requested: everything freezes.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 1, 0, 32'(32'h4000 + i * 4));
        end
        applyStimulus(0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0);
            checkOutput($sformatf("frozen%0d", i));
            checkVal($sformatf("frozen%0d.pc", i), 64'(pc_out), 64'(32'h4000));
        end
        applyStimulus(0, 0, 1, 0, 1, 0);
        checkVal("resume.pc", 64'(pc_out), 64'(32'h4004));
        checkOutput("resume");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 39) == 0,
                          $urandom_range(0, 9) != 0,
                          $urandom_range(0, 2) != 0,
                          $urandom_range(0, 2) == 0 ? 1'b0 : ($urandom_range(0, 1) == 1),
                          $urandom());
            checkOutput($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
